// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the latency counter width.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  localparam int CNT_W = 4;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Returns {hi,lo} and a divide-by-zero
// flag. Signed division is done on magnitudes so MIN_INT / -1 wraps cleanly.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] ua, ub, ub_safe, q, r, quo, rem;
  logic        neg_a, neg_b, sgn;

  always_comb begin
    a_ext = {32'b0, d1};
    b_ext = {32'b0, d2};
    if (op == OP_MULT) begin
      a_ext = {{32{d1[31]}}, d1};
      b_ext = {{32{d2[31]}}, d2};
    end
    prod = a_ext * b_ext;

    sgn     = (op == OP_DIV);
    neg_a   = sgn & d1[31];
    neg_b   = sgn & d2[31];
    ua      = neg_a ? (~d1 + 32'd1) : d1;
    ub      = neg_b ? (~d2 + 32'd1) : d2;
    // substitute divisor keeps the divider defined; the result is discarded
    ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    q       = ua / ub_safe;
    r       = ua % ub_safe;
    quo     = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
    rem     = neg_a ? (~r + 32'd1) : r;

    div_by_zero = is_div_op(op) && (d2 == 32'd0);

    result = 64'd0;
    if (op == OP_MULT || op == OP_MULTU) result = prod;
    else if (is_div_op(op))              result = {rem, quo};
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: fixed-latency FSM, pending result
// registers and the architectural HI/LO pair.
//
// state | meaning
// IDLE  | no operation in flight; accepts Start and MTHI/MTLO
// RUN   | counting down latency; commits pending result at count 1
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        hi, hi_nxt, lo, lo_nxt;
  logic [31:0]        pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
  logic               pend_dz, pend_dz_nxt;
  logic               busy, busy_nxt;
  logic [63:0]        calc_res;
  logic               calc_dz;

  md_calc u_calc (
    .op          (MDOp),
    .d1          (D1),
    .d2          (D2),
    .result      (calc_res),
    .div_by_zero (calc_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_dz <= pend_dz_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_dz_nxt = pend_dz;
    busy_nxt    = busy;
    case (state)
      ST_IDLE: begin
        if (Start && is_md_op(MDOp)) begin
          pend_hi_nxt = calc_res[63:32];
          pend_lo_nxt = calc_res[31:0];
          pend_dz_nxt = calc_dz;
          cnt_nxt     = is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_nxt   = ST_RUN;
          busy_nxt    = 1'b1;
        end else if (MDOp == OP_MTHI) begin
          hi_nxt = D1;
        end else if (MDOp == OP_MTLO) begin
          lo_nxt = D1;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (!pend_dz) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Busy = busy;
  assign HI   = hi;
  assign LO   = lo;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: table of operations with expected HI/LO and latency,
// scoreboarded results, plus interference, operand-change and reset sequences.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] D1, D2;
  logic        Busy;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .D1    (D1),
    .D2    (D2),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        commit;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        tbl [14];
  exp_t        sb [$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // mode 0: plain, 1: Start/MTHI interference during RUN, 2: operand churn during RUN
  task automatic run_op(input vec_t v, input int mode);
    exp_t e;
    int   n;
    @(negedge clk);
    Start = v.start; MDOp = v.op; D1 = v.d1; D2 = v.d2;
    if (v.cyc > 0) begin
      e.hi = v.commit ? v.hi : m_hi;
      e.lo = v.commit ? v.lo : m_lo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0;
    if (v.cyc == 0) begin
      chk("busy_single", 32'(Busy), 32'd0);
      chk("hi_single", HI, v.hi);
      chk("lo_single", LO, v.lo);
      m_hi = v.hi; m_lo = v.lo;
    end else begin
      chk("busy_start", 32'(Busy), 32'd1);
      chk("hi_during_run", HI, m_hi);
      chk("lo_during_run", LO, m_lo);
      n = 0;
      while (Busy && n < 40) begin
        @(negedge clk);
        if (mode == 1 && n == 0) begin
          Start = 1'b1; MDOp = 3'd3; D1 = 32'd100; D2 = 32'd7;
        end else if (mode == 1 && n == 1) begin
          MDOp = 3'd5; D1 = 32'h0000DEAD;
        end else if (mode == 2) begin
          D1 = $urandom; D2 = $urandom;
        end
        @(posedge clk); #1;
        Start = 1'b0; MDOp = 3'd0;
        n++;
      end
      chk("busy_cycles", 32'(n), 32'(v.cyc));
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk("hi_result", HI, e.hi);
        chk("lo_result", LO, e.lo);
        m_hi = e.hi; m_lo = e.lo;
      end
    end
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{1'b1, 3'd1, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, 5,  1'b1};
    tbl[1]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b1};
    tbl[2]  = '{1'b1, 3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
    tbl[3]  = '{1'b1, 3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10, 1'b1};
    tbl[4]  = '{1'b0, 3'd5, 32'h11,       32'd0,        32'h11,       32'd14,       0,  1'b1};
    tbl[5]  = '{1'b0, 3'd6, 32'h22,       32'd0,        32'h11,       32'h22,       0,  1'b1};
    tbl[6]  = '{1'b1, 3'd4, 32'd5,        32'd0,        32'h0,        32'h0,        10, 1'b0};
    tbl[7]  = '{1'b1, 3'd3, 32'hFFFFFF00, 32'd0,        32'h0,        32'h0,        10, 1'b0};
    tbl[8]  = '{1'b1, 3'd0, 32'h99,       32'h99,       32'h11,       32'h22,       0,  1'b1};
    tbl[9]  = '{1'b1, 3'd7, 32'h99,       32'h99,       32'h11,       32'h22,       0,  1'b1};
    tbl[10] = '{1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10, 1'b1};
    tbl[11] = '{1'b1, 3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, 1'b1};
    tbl[12] = '{1'b1, 3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5,  1'b1};
    tbl[13] = '{1'b1, 3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10, 1'b1};

    reset = 1'b0; Start = 1'b0; MDOp = 3'd0; D1 = '0; D2 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 14; i++) run_op(tbl[i], 0);

    // interference while a MULT is running
    v = '{1'b1, 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5, 1'b1};
    run_op(v, 1);
    // operand churn during RUN, then a back-to-back start
    v = '{1'b1, 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b1};
    run_op(v, 2);
    v = '{1'b1, 3'd4, 32'd50, 32'd8, 32'd2, 32'd6, 10, 1'b1};
    run_op(v, 0);

    // reset three cycles into a DIV aborts it
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd3; D1 = 32'd1000; D2 = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_abort_busy", 32'(Busy), 32'd0);
    chk("post_abort_hi", HI, 32'd0);
    chk("post_abort_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
